// File: rtl/bus_err_drain.sv
// bus_err_drain: drains logged AXI error records from the error-unit wrapper's reg port into a record stream.
// Optional BUS_ERR_DRAIN_CNT_EN adds per-source saturating record counters (cnt_wr_o, cnt_rd_o).
package bus_err_drain_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module bus_err_drain #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned MetaDataWidth = 2,
    parameter int unsigned ErrBits       = 2,
    parameter logic [31:0] BaseAddr      = '0,
    parameter logic [31:0] OffCode       = 32'h0,
    parameter logic [31:0] OffAddr       = 32'h4,
    parameter logic [31:0] OffMeta       = 32'h8,
    parameter logic [31:0] OffPop        = 32'hC,
    parameter type reg_req_t = bus_err_drain_pkg::reg_req_t,
    parameter type reg_rsp_t = bus_err_drain_pkg::reg_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               err_irq_i,
    output reg_req_t                 reg_req_o,
    input  reg_rsp_t                 reg_rsp_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic                     rec_src_o,
    output logic [ErrBits-1:0]       rec_code_o,
    output logic [AddrWidth-1:0]     rec_addr_o,
    output logic [MetaDataWidth-1:0] rec_meta_o,
    output logic                     bus_err_o,
`ifdef BUS_ERR_DRAIN_CNT_EN
    output logic [31:0]              cnt_wr_o,
    output logic [31:0]              cnt_rd_o,
`endif
    output logic                     busy_o
);
    typedef enum logic [2:0] {IDLE, RD_CODE, RD_ADDR, RD_META, EMIT, POP} state_t;

    state_t state;
    logic   rr;
    logic   pick;
    logic   hs;
    logic   unused_rsp;

    assign pick       = &err_irq_i ? rr : err_irq_i[1];
    assign hs         = reg_req_o.valid & reg_rsp_i.ready;
    assign busy_o     = state != IDLE;
    assign unused_rsp = ^reg_rsp_i;

    function automatic reg_req_t access(input logic s, input logic [31:0] off, input logic wr);
        reg_req_t r;
        r       = '0;
        r.addr  = BaseAddr + (s ? 32'h20 : 32'h0) + off;
        r.write = wr;
        r.wstrb = {$bits(r.wstrb){wr}};
        r.valid = 1'b1;
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            reg_req_o   <= '0;
            rec_valid_o <= 1'b0;
            rec_src_o   <= 1'b0;
            rec_code_o  <= '0;
            rec_addr_o  <= '0;
            rec_meta_o  <= '0;
            bus_err_o   <= 1'b0;
            rr          <= 1'b0;
`ifdef BUS_ERR_DRAIN_CNT_EN
            cnt_wr_o    <= '0;
            cnt_rd_o    <= '0;
`endif
        end else if (hs && reg_rsp_i.error) begin
            // any failed access poisons the drain until reset
            bus_err_o <= 1'b1;
            reg_req_o <= '0;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: if (|err_irq_i && !bus_err_o) begin
                    rec_src_o <= pick;
                    rr        <= &err_irq_i ? ~rr : rr;
                    reg_req_o <= access(pick, OffCode, 1'b0);
                    state     <= RD_CODE;
                end
                RD_CODE: if (hs) begin
                    rec_code_o <= reg_rsp_i.rdata[ErrBits-1:0];
                    if (reg_rsp_i.rdata[ErrBits-1:0] == '0) begin
                        reg_req_o <= '0;
                        state     <= IDLE;
                    end else begin
                        reg_req_o <= access(rec_src_o, OffAddr, 1'b0);
                        state     <= RD_ADDR;
                    end
                end
                RD_ADDR: if (hs) begin
                    rec_addr_o <= reg_rsp_i.rdata[AddrWidth-1:0];
                    reg_req_o  <= access(rec_src_o, OffMeta, 1'b0);
                    state      <= RD_META;
                end
                RD_META: if (hs) begin
                    rec_meta_o  <= reg_rsp_i.rdata[MetaDataWidth-1:0];
                    reg_req_o   <= '0;
                    rec_valid_o <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: if (rec_ready_i) begin
                    rec_valid_o <= 1'b0;
                    reg_req_o   <= access(rec_src_o, OffPop, 1'b1);
                    state       <= POP;
`ifdef BUS_ERR_DRAIN_CNT_EN
                    if (rec_src_o) cnt_rd_o <= cnt_rd_o + 32'(~&cnt_rd_o);
                    else cnt_wr_o <= cnt_wr_o + 32'(~&cnt_wr_o);
`endif
                end
                POP: if (hs) begin
                    reg_req_o <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_err_drain.sv
// tb_bus_err_drain: directed bench with a two-unit error-log reg slave model.
module tb_bus_err_drain;
    localparam logic [31:0] BASE = 32'h4000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] irq;
    bus_err_drain_pkg::reg_req_t req;
    bus_err_drain_pkg::reg_rsp_t rsp;
    logic rec_valid, rec_ready = 1'b1, rec_src, bus_err, busy;
    logic [1:0] rec_code, rec_meta;
    logic [31:0] rec_addr;
`ifdef BUS_ERR_DRAIN_CNT_EN
    logic [31:0] cnt_wr, cnt_rd;
`endif

    bus_err_drain #(.BaseAddr(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .err_irq_i(irq), .reg_req_o(req), .reg_rsp_i(rsp),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_src_o(rec_src),
        .rec_code_o(rec_code), .rec_addr_o(rec_addr), .rec_meta_o(rec_meta), .bus_err_o(bus_err),
`ifdef BUS_ERR_DRAIN_CNT_EN
        .cnt_wr_o(cnt_wr), .cnt_rd_o(cnt_rd),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [31:0] e_code[2][16], e_addr[2][16], e_meta[2][16];
    logic [3:0] wr_n[2] = '{4'd0, 4'd0};
    logic [3:0] skip[2] = '{4'd0, 4'd0};
    logic [3:0] rd_n[2] = '{4'd0, 4'd0};
    logic err_en = 1'b0, stall_meta = 1'b0;
    logic [31:0] err_addr = '0;
    int acc_n = 0, bad_n = 0, addr_rd_n = 0;
    logic [3:0] pop_n = '0, rec_n = '0;
    logic rl_src[16], pl_u[16];
    logic [1:0] rl_code[16], rl_meta[16];
    logic [31:0] rl_addr[16];

    logic [31:0] rel;
    logic u;
    logic [4:0] off;
    logic [3:0] h;

    assign irq = {wr_n[1] != rd_n[1] + skip[1], wr_n[0] != rd_n[0] + skip[0]};

    always_comb begin
        rel = req.addr - BASE;
        u = rel[5];
        off = rel[4:0];
        h = rd_n[u] + skip[u];
        rsp = '0;
        rsp.ready = req.valid && !(stall_meta && off == 5'h8 && !req.write);
        rsp.error = req.valid && err_en && req.addr == err_addr;
        rsp.rdata = off == 5'h0 ? e_code[u][h] : off == 5'h4 ? e_addr[u][h] : off == 5'h8 ? e_meta[u][h] : 32'h0;
    end

    always @(posedge clk) begin
        if (req.valid && rsp.ready) begin
            acc_n <= acc_n + 1;
            if (rel >= 32'h40 || rel[1:0] != 2'b0 || (!req.write && req.wstrb != 4'h0) ||
                (req.write && (off != 5'hC || req.wdata != 32'h0 || req.wstrb != 4'hF)))
                bad_n <= bad_n + 1;
            if (!req.write && off == 5'h4) addr_rd_n <= addr_rd_n + 1;
            if (req.write && !rsp.error) begin
                pl_u[pop_n] <= u;
                pop_n <= pop_n + 4'd1;
                rd_n[u] <= rd_n[u] + 4'd1;
            end
        end
        if (rec_valid && rec_ready) begin
            rl_src[rec_n] <= rec_src;
            rl_code[rec_n] <= rec_code;
            rl_addr[rec_n] <= rec_addr;
            rl_meta[rec_n] <= rec_meta;
            rec_n <= rec_n + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int s, input logic [31:0] c, input logic [31:0] a, input logic [31:0] m);
        e_code[s][wr_n[s]] = c;
        e_addr[s][wr_n[s]] = a;
        e_meta[s][wr_n[s]] = m;
        wr_n[s] = wr_n[s] + 4'd1;
    endtask

    task automatic wait_done(input string tag, input logic [3:0] recs, input int lim);
        int c = 0;
        while ((rec_n != recs || busy) && c < lim) begin
            tick(1);
            c++;
        end
        chk({tag, " done"}, 32'(c < lim), 32'd1);
    endtask

    initial begin
        int c, p, a;
        logic ok;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) begin
                e_code[s][i] = '0;
                e_addr[s][i] = '0;
                e_meta[s][i] = '0;
            end
        tick(3);
        chk("rst req_valid", 32'(req.valid), 32'd0);
        chk("rst rec_valid", 32'(rec_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst fields", 32'({rec_src, rec_code, rec_meta}), 32'd0);
        chk("rst addr", rec_addr, 32'd0);
        rst = 1'b0;
        tick(2);
        chk("idle busy", 32'(busy), 32'd0);

        push(0, 32'h2, 32'h8000_0010, 32'h1);
        c = 0;
        while (!rec_valid && c < 20) begin
            tick(1);
            c++;
        end
        chk("t1 latency", c, 32'd4);
        chk("t1 src", 32'(rec_src), 32'd0);
        chk("t1 code", 32'(rec_code), 32'd2);
        chk("t1 addr", rec_addr, 32'h8000_0010);
        chk("t1 meta", 32'(rec_meta), 32'd1);
        wait_done("t1", 4'd1, 20);
        chk("t1 pops", 32'(pop_n), 32'd1);
        chk("t1 pop unit", 32'(pl_u[0]), 32'd0);

        push(0, 32'h1, 32'h0000_1000, 32'h2);
        push(1, 32'h2, 32'h0000_2000, 32'h0);
        push(0, 32'h3, 32'h0000_1004, 32'h3);
        push(1, 32'h1, 32'h0000_2004, 32'h1);
        wait_done("t2", 4'd5, 100);
        chk("t2 pops", 32'(pop_n), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk("t2 src", 32'(rl_src[1+i]), 32'(i % 2));
            chk("t2 pop unit", 32'(pl_u[1+i]), 32'(i % 2));
        end
        chk("t2 code0", 32'(rl_code[1]), 32'd1);
        chk("t2 code1", 32'(rl_code[2]), 32'd2);
        chk("t2 code2", 32'(rl_code[3]), 32'd3);
        chk("t2 addr3", rl_addr[4], 32'h0000_2004);
        chk("t2 meta2", 32'(rl_meta[3]), 32'd3);

        rec_ready = 1'b0;
        push(0, 32'h3, 32'h1234_5678, 32'h2);
        c = 0;
        while (!rec_valid && c < 20) begin
            tick(1);
            c++;
        end
        chk("t3 emit", 32'(rec_valid), 32'd1);
        p = 32'(pop_n);
        ok = 1'b1;
        repeat (10) begin
            tick(1);
            if (!rec_valid || rec_code != 2'd3 || rec_addr != 32'h1234_5678 || rec_meta != 2'd2 || req.valid)
                ok = 1'b0;
        end
        chk("t3 stable", 32'(ok), 32'd1);
        chk("t3 no pop", 32'(pop_n), p);
        chk("t3 busy", 32'(busy), 32'd1);
        rec_ready = 1'b1;
        wait_done("t3", 4'd6, 20);
        chk("t3 pop after", 32'(pop_n), 32'd6);

        a = addr_rd_n;
        push(1, 32'h0, 32'h0000_dead, 32'h1);
        tick(12);
        chk("t4 no rec", 32'(rec_n), 32'd6);
        chk("t4 no pop", 32'(pop_n), 32'd6);
        chk("t4 no addr rd", addr_rd_n, a);
        skip[1] = skip[1] + 4'd1;
        tick(4);
        chk("t4 idle", 32'(busy), 32'd0);

        err_en = 1'b1;
        err_addr = BASE + 32'h4;
        push(0, 32'h1, 32'h0000_aaaa, 32'h3);
        tick(10);
        chk("t5 bus_err", 32'(bus_err), 32'd1);
        chk("t5 no rec", 32'(rec_n), 32'd6);
        chk("t5 no pop", 32'(pop_n), 32'd6);
        chk("t5 idle", 32'(busy), 32'd0);
        err_en = 1'b0;
        a = acc_n;
        push(1, 32'h2, 32'h0000_bbbb, 32'h0);
        ok = 1'b0;
        repeat (10) begin
            tick(1);
            if (busy) ok = 1'b1;
        end
        chk("t5 inhibit busy", 32'(ok), 32'd0);
        chk("t5 inhibit acc", acc_n, a);

        stall_meta = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        #0;
        chk("t6 bus_err clr", 32'(bus_err), 32'd0);
        c = 0;
        while (!(req.valid && rel[4:0] == 5'h8) && c < 20) begin
            tick(1);
            c++;
        end
        chk("t6 in meta", 32'(c < 20), 32'd1);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("t6 req_valid", 32'(req.valid), 32'd0);
        chk("t6 rec_valid", 32'(rec_valid), 32'd0);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 no pop", 32'(pop_n), 32'd6);
        rst = 1'b0;
        stall_meta = 1'b0;
        wait_done("t6", 4'd8, 60);
        chk("t6 src0", 32'(rl_src[6]), 32'd0);
        chk("t6 src1", 32'(rl_src[7]), 32'd1);
        chk("t6 addr0", rl_addr[6], 32'h0000_aaaa);
        chk("t6 addr1", rl_addr[7], 32'h0000_bbbb);
        chk("t6 pops", 32'(pop_n), 32'd8);
`ifdef BUS_ERR_DRAIN_CNT_EN
        chk("cnt wr", cnt_wr, 32'd1);
        chk("cnt rd", cnt_rd, 32'd1);
`endif
        chk("bad accesses", bad_n, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
